// File: rtl/fust_scalar_table.sv
// -----------------------------------------------------------------------------
// fust_scalar_table
//
// Scalar functional-unit status table. It sits between dispatch and the scalar
// execute units and holds one row per scalar FU (ALU=0, LD_ST=1, BRANCH=2).
// Each row records the tags of its operand producers and clears them when it
// sees a matching writeback broadcast. At most one ready row issues per cycle.
// A row is freed when its own FU writes back.
//
// Configuration macro: FUST_WB_BYPASS_EN
//   defined   : a dispatch whose t1/t2 matches a same-cycle writeback tag is
//               accepted, and that tag is captured as resolved (0).
//   undefined : such a dispatch is held off (disp_ready=0), and dispatch
//               retries on the next cycle.
//
// Ports
//   CLK, RST     clock (rising edge); asynchronous active-high reset
//   disp_valid   dispatch presents an instruction
//   disp_fu      target row (fu_scalar_t); 3 is illegal and never accepted
//   disp_row     row payload (busy field ignored)
//   disp_ready   row free, legal target, no flush, no unresolved wb conflict
//   wb_valid     writeback broadcast valid
//   wb_tag       completing FU tag (FU index + 1); 0 is ignored
//   flush        squash WAIT/RDY rows; blocks issue and dispatch this cycle
//   fu_ready     per-FU accept
//   issue_valid  a row issues this cycle
//   issue_fu     issued row index (0 when idle)
//   issue_row    issued row contents with t1 = t2 = 0 (0 when idle)
//   fust         live table snapshot; busy = state != EMPTY
//   row_state    per-row state
// -----------------------------------------------------------------------------
package fust_scalar_pkg;
  localparam int FU_S_W     = 2;
  localparam int FUST_NROWS = 3;

  typedef enum logic [FU_S_W-1:0] {
    FU_ALU    = 2'd0,
    FU_LD_ST  = 2'd1,
    FU_BRANCH = 2'd2
  } fu_scalar_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    RDY   = 2'd2,
    EX    = 2'd3
  } fust_state_e;

  typedef struct packed {
    logic              busy;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [FU_S_W-1:0] t1;
    logic [FU_S_W-1:0] t2;
  } fust_s_row_t;

  typedef fust_s_row_t [FUST_NROWS-1:0] fust_s_t;
endpackage

module fust_scalar_table
  import fust_scalar_pkg::*;
#(
  parameter int NROWS = FUST_NROWS,
  parameter int TAG_W = FU_S_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    disp_valid,
  input  logic [1:0]              disp_fu,
  input  fust_s_row_t             disp_row,
  output logic                    disp_ready,
  input  logic                    wb_valid,
  input  logic [TAG_W-1:0]        wb_tag,
  input  logic                    flush,
  input  logic [NROWS-1:0]        fu_ready,
  output logic                    issue_valid,
  output logic [1:0]              issue_fu,
  output fust_s_row_t             issue_row,
  output fust_s_t                 fust,
  output fust_state_e [NROWS-1:0] row_state
);

  fust_state_e r_state [NROWS];
  fust_s_row_t r_row   [NROWS];

  logic        w_wb_hit;
  logic        w_fu_legal;
  logic        w_row_empty;
  logic        w_tag_conflict;
  logic        w_wb_block;
  logic        w_accept;
  fust_s_row_t w_disp_cap;

  assign w_wb_hit       = wb_valid && (wb_tag != '0);
  assign w_fu_legal     = (disp_fu < 2'(NROWS));
  assign w_tag_conflict = w_wb_hit && ((disp_row.t1 == wb_tag) || (disp_row.t2 == wb_tag));

`ifdef FUST_WB_BYPASS_EN
  assign w_wb_block = 1'b0;
`else
  assign w_wb_block = w_tag_conflict;
`endif

  // Target row must be free in registered state; a row freed this cycle is
  // not visible as EMPTY until the next cycle.
  always_comb begin
    w_row_empty = 1'b0;
    for (int i = 0; i < NROWS; i++) begin
      if (disp_fu == 2'(i)) w_row_empty = (r_state[i] == EMPTY);
    end
  end

  assign disp_ready = !flush && w_fu_legal && w_row_empty && !w_wb_block;
  assign w_accept   = disp_valid && disp_ready;

  // Captured payload: a tag resolved by this cycle's writeback is stored as 0.
  // Without the bypass, a conflicting dispatch is never accepted, so this
  // clearing has no effect in that build.
  always_comb begin
    w_disp_cap      = disp_row;
    w_disp_cap.busy = 1'b0;
    if (w_wb_hit && (disp_row.t1 == wb_tag)) w_disp_cap.t1 = '0;
    if (w_wb_hit && (disp_row.t2 == wb_tag)) w_disp_cap.t2 = '0;
  end

  // Fixed-priority select: the ascending loop lets the highest index win.
  always_comb begin
    issue_valid = 1'b0;
    issue_fu    = '0;
    issue_row   = '0;
    for (int i = 0; i < NROWS; i++) begin
      if (!flush && (r_state[i] == RDY) && fu_ready[i]) begin
        issue_valid    = 1'b1;
        issue_fu       = 2'(i);
        issue_row      = r_row[i];
        issue_row.busy = 1'b1;
        issue_row.t1   = '0;
        issue_row.t2   = '0;
      end
    end
  end

  always_comb begin
    fust = '0;
    for (int i = 0; i < NROWS; i++) begin
      fust[i]      = r_row[i];
      fust[i].busy = (r_state[i] != EMPTY);
      row_state[i] = r_state[i];
    end
  end

  for (genvar g = 0; g < NROWS; g++) begin : g_row
    localparam logic [TAG_W-1:0] ROW_TAG = TAG_W'(g + 1);

    logic              w_t1_wk;
    logic              w_t2_wk;
    logic [FU_S_W-1:0] w_t1_next;
    logic [FU_S_W-1:0] w_t2_next;
    logic              w_own_wb;
    logic              w_disp_here;
    logic              w_issue_here;

    assign w_t1_wk      = w_wb_hit && (r_row[g].t1 == wb_tag);
    assign w_t2_wk      = w_wb_hit && (r_row[g].t2 == wb_tag);
    assign w_t1_next    = w_t1_wk ? '0 : r_row[g].t1;
    assign w_t2_next    = w_t2_wk ? '0 : r_row[g].t2;
    assign w_own_wb     = w_wb_hit && (wb_tag == ROW_TAG);
    assign w_disp_here  = w_accept && (disp_fu == 2'(g));
    assign w_issue_here = issue_valid && (issue_fu == 2'(g));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_state[g] <= EMPTY;
        r_row[g]   <= '0;
      end else begin
        case (r_state[g])
          EMPTY: begin
            if (w_disp_here) begin
              r_row[g]   <= w_disp_cap;
              r_state[g] <= ((w_disp_cap.t1 != '0) || (w_disp_cap.t2 != '0)) ? WAIT : RDY;
            end
          end
          WAIT: begin
            // Flush beats a same-cycle wakeup.
            if (flush) begin
              r_state[g] <= EMPTY;
              r_row[g]   <= '0;
            end else begin
              r_row[g].t1 <= w_t1_next;
              r_row[g].t2 <= w_t2_next;
              if ((w_t1_next == '0) && (w_t2_next == '0)) r_state[g] <= RDY;
            end
          end
          RDY: begin
            if (flush) begin
              r_state[g] <= EMPTY;
              r_row[g]   <= '0;
            end else begin
              r_row[g].t1 <= w_t1_next;
              r_row[g].t2 <= w_t2_next;
              if (w_issue_here) r_state[g] <= EX;
            end
          end
          EX: begin
            // Executing rows survive flush and free only on their own writeback.
            if (w_own_wb) begin
              r_state[g] <= EMPTY;
              r_row[g]   <= '0;
            end else begin
              r_row[g].t1 <= w_t1_next;
              r_row[g].t2 <= w_t2_next;
            end
          end
          default: begin
            r_state[g] <= EMPTY;
            r_row[g]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fust_scalar_table.sv
module tb_fust_scalar_table;
  import fust_scalar_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic              disp_valid;
  logic [1:0]        disp_fu;
  fust_s_row_t       disp_row;
  logic              disp_ready;
  logic              wb_valid;
  logic [1:0]        wb_tag;
  logic              flush;
  logic [2:0]        fu_ready;
  logic              issue_valid;
  logic [1:0]        issue_fu;
  fust_s_row_t       issue_row;
  fust_s_t           fust;
  fust_state_e [2:0] row_state;

  always #5 CLK = ~CLK;

  fust_scalar_table #(.NROWS(3), .TAG_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_row(disp_row), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_row(issue_row),
    .fust(fust), .row_state(row_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  fu;
    fust_s_row_t row;
  } iss_t;
  iss_t sb_q[$];

  // Reference table: what each FU slot holds and where it is in its life.
  fust_state_e m_st  [3];
  fust_s_row_t m_row [3];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i]  = EMPTY;
      m_row[i] = '0;
    end
  endfunction

  function automatic fust_s_row_t mkrow(input logic [4:0] rd, input logic [1:0] t1, input logic [1:0] t2);
    fust_s_row_t r;
    r.busy = 1'($urandom);
    r.rd   = rd;
    r.rs1  = 5'($urandom);
    r.rs2  = 5'($urandom);
    r.imm  = $urandom;
    r.t1   = t1;
    r.t2   = t2;
    return r;
  endfunction

  // One clock cycle: drive inputs, check against the reference, advance it.
  task automatic step(input logic dv, input logic [1:0] dfu, input fust_s_row_t drow,
                      input logic wbv, input logic [1:0] wbt, input logic fl, input logic [2:0] fr);
    logic        hit, rdy;
    int          isel;
    fust_s_row_t cap;
    fust_state_e nst [3];
    fust_s_row_t nrow[3];
    fust_s_t     exp_f;
    logic [5:0]  exp_rs, act_rs;
    iss_t        e;
    @(negedge CLK);
    disp_valid = dv; disp_fu = dfu; disp_row = drow;
    wb_valid = wbv; wb_tag = wbt; flush = fl; fu_ready = fr;
    cyc++;
    #1;
    hit = wbv && (wbt != 2'd0);
    rdy = 1'b0;
    if (dfu != 2'd3) rdy = !fl && (m_st[dfu] == EMPTY);
`ifndef FUST_WB_BYPASS_EN
    if (hit && ((drow.t1 == wbt) || (drow.t2 == wbt))) rdy = 1'b0;
`endif
    chk("disp_ready", disp_ready, rdy);

    for (int i = 0; i < 3; i++) begin
      exp_f[i]          = m_row[i];
      exp_f[i].busy     = (m_st[i] != EMPTY);
      exp_rs[i*2 +: 2]  = m_st[i];
    end
    act_rs = {row_state[2], row_state[1], row_state[0]};
    chk("row_state", act_rs, exp_rs);
    chk("fust", fust, exp_f);

    isel = -1;
    if (!fl) begin
      for (int i = 2; i >= 0; i--) begin
        if (isel < 0 && m_st[i] == RDY && fr[i]) isel = i;
      end
    end
    if (isel >= 0) begin
      e.cyc = cyc; e.fu = 2'(isel);
      e.row = m_row[isel]; e.row.busy = 1'b1; e.row.t1 = '0; e.row.t2 = '0;
      sb_q.push_back(e);
    end

    for (int i = 0; i < 3; i++) begin
      nst[i]  = m_st[i];
      nrow[i] = m_row[i];
      if (m_st[i] != EMPTY) begin
        if (hit && m_row[i].t1 == wbt) nrow[i].t1 = '0;
        if (hit && m_row[i].t2 == wbt) nrow[i].t2 = '0;
      end
      if ((fl && (m_st[i] == WAIT || m_st[i] == RDY)) ||
          (m_st[i] == EX && hit && int'(wbt) == i + 1)) begin
        nst[i]  = EMPTY;
        nrow[i] = '0;
      end else if (m_st[i] == WAIT && nrow[i].t1 == 0 && nrow[i].t2 == 0) begin
        nst[i] = RDY;
      end else if (m_st[i] == RDY && isel == i) begin
        nst[i] = EX;
      end
    end
    if (dv && rdy) begin
      cap = drow; cap.busy = 1'b0;
      if (hit && cap.t1 == wbt) cap.t1 = '0;
      if (hit && cap.t2 == wbt) cap.t2 = '0;
      nrow[dfu] = cap;
      nst[dfu]  = (cap.t1 == 0 && cap.t2 == 0) ? RDY : WAIT;
    end
    for (int i = 0; i < 3; i++) begin
      m_st[i]  = nst[i];
      m_row[i] = nrow[i];
    end
  endtask

  task automatic idle(input logic [2:0] fr);
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0, fr);
  endtask

  task automatic wb(input logic [1:0] t, input logic [2:0] fr);
    step(1'b0, 2'd0, '0, 1'b1, t, 1'b0, fr);
  endtask

  task automatic disp(input logic [1:0] fu, input fust_s_row_t r, input logic [2:0] fr);
    step(1'b1, fu, r, 1'b0, 2'd0, 1'b0, fr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_issue_valid"}, issue_valid, 1'b0);
    chk({tag, "_issue_fu"}, issue_fu, 2'd0);
    chk({tag, "_issue_row"}, issue_row, '0);
    chk({tag, "_fust"}, fust, '0);
    chk({tag, "_row_state"}, {row_state[2], row_state[1], row_state[0]}, 6'd0);
    chk({tag, "_disp_ready"}, disp_ready, 1'b1);
  endtask

  task automatic zero_inputs();
    disp_valid = 0; disp_fu = 0; disp_row = '0;
    wb_valid = 0; wb_tag = 0; flush = 0; fu_ready = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues.
  initial begin
    iss_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RST) continue;
      if (issue_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL issue_unexpected: got fu %0d expected no issue (cycle %0d)", issue_fu, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_fu", issue_fu, e.fu);
          chk("issue_row", issue_row, e.row);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL issue_missing: got no issue expected fu %0d (cycle %0d)", e.fu, cyc);
      end else begin
        chk("issue_idle", {issue_fu, issue_row}, '0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    zero_inputs();
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b0;

    // Independent dispatch issues the next cycle, then runs.
    disp(2'd0, mkrow(5'd5, 2'd0, 2'd0), 3'b111);
    chk("t1_state0_empty", row_state[0], EMPTY);
    idle(3'b111);
    chk("t1_issue_valid", issue_valid, 1'b1);
    chk("t1_issue_fu", issue_fu, 2'd0);
    disp(2'd1, mkrow(5'd6, 2'd1, 2'd0), 3'b111);
    chk("t1_state0_ex", row_state[0], EX);
    wb(2'd1, 3'b111);
    chk("t2_state1_wait", row_state[1], WAIT);
    idle(3'b111);
    chk("t2_state0_freed", row_state[0], EMPTY);
    chk("t2_state1_rdy", row_state[1], RDY);
    chk("t2_issue_fu", issue_fu, 2'd1);
    chk("t2_alu_ready", disp_ready, 1'b1);
    wb(2'd2, 3'b000);

    // Priority 2 > 1 > 0.
    for (int i = 0; i < 3; i++) disp(2'(i), mkrow(5'(i), 2'd0, 2'd0), 3'b000);
    idle(3'b111); chk("prio_first", issue_fu, 2'd2);
    idle(3'b111); chk("prio_second", issue_fu, 2'd1);
    idle(3'b111); chk("prio_third", issue_fu, 2'd0);
    wb(2'd3, 0); wb(2'd2, 0); wb(2'd1, 0);

    // BRANCH not ready: LD_ST wins.
    for (int i = 0; i < 3; i++) disp(2'(i), mkrow(5'(i + 8), 2'd0, 2'd0), 3'b000);
    idle(3'b011); chk("prio_masked", issue_fu, 2'd1);
    idle(3'b011); idle(3'b100);
    wb(2'd1, 0); wb(2'd2, 0); wb(2'd3, 0);

    // Dispatch depending on a same-cycle writeback.
    disp(2'd2, mkrow(5'd1, 2'd0, 2'd0), 3'b000);
    idle(3'b100);
    step(1'b1, 2'd0, mkrow(5'd7, 2'd0, 2'd3), 1'b1, 2'd3, 1'b0, 3'b000);
`ifdef FUST_WB_BYPASS_EN
    chk("byp_ready", disp_ready, 1'b1);
`else
    chk("byp_blocked", disp_ready, 1'b0);
    disp(2'd0, mkrow(5'd7, 2'd0, 2'd0), 3'b000);
    chk("byp_retry", disp_ready, 1'b1);
`endif
    idle(3'b000);
    chk("byp_rdy", row_state[0], RDY);
    idle(3'b001); wb(2'd1, 0);

    // Flush keeps EX, drops WAIT/RDY.
    disp(2'd0, mkrow(5'd3, 2'd0, 2'd0), 3'b000);
    idle(3'b001);
    disp(2'd1, mkrow(5'd4, 2'd1, 2'd0), 3'b000);
    disp(2'd2, mkrow(5'd9, 2'd0, 2'd0), 3'b000);
    step(1'b1, 2'd0, mkrow(5'd2, 2'd0, 2'd0), 1'b0, 2'd0, 1'b1, 3'b111);
    chk("flush_no_issue", issue_valid, 1'b0);
    chk("flush_no_disp", disp_ready, 1'b0);
    idle(3'b000);
    chk("flush_ex_kept", row_state[0], EX);
    chk("flush_wait_gone", row_state[1], EMPTY);
    chk("flush_rdy_gone", row_state[2], EMPTY);
    wb(2'd1, 0);
    idle(0);
    chk("flush_ex_freed", row_state[0], EMPTY);

    // Flush and wakeup together: flush wins.
    disp(2'd0, mkrow(5'd3, 2'd0, 2'd0), 3'b000);
    idle(3'b001);
    disp(2'd1, mkrow(5'd4, 2'd1, 2'd0), 3'b000);
    step(1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b1, 3'b000);
    idle(0);
    chk("flush_wk_row1", row_state[1], EMPTY);

    // Asynchronous reset mid-operation.
    disp(2'd0, mkrow(5'd3, 2'd0, 2'd0), 3'b000);
    disp(2'd1, mkrow(5'd4, 2'd1, 2'd0), 3'b001);
    #2;
    RST = 1'b1;
    zero_inputs();
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    sb_q.delete();
    @(negedge CLK);
    RST = 1'b0;

    // Randomized traffic.
    repeat (3000) begin
      logic       dv, wbv, fl;
      logic [1:0] dfu, wbt, t1, t2;
      dv  = ($urandom_range(0, 9) < 6);
      dfu = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t1  = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
      t2  = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
      wbv = ($urandom_range(0, 9) < 4);
      wbt = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 19) == 0);
      step(dv, dfu, mkrow(5'($urandom), t1, t2), wbv, wbt, fl, 3'($urandom_range(0, 7)));
    end
    idle(0);
    idle(0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fust_scalar_table.md
# fust_scalar_table

Scalar functional-unit status table for the scoreboard pipeline. Sits between dispatch and the scalar execute units. It holds one row per scalar FU (ALU, LD/ST, BRANCH). Each row tracks operand-producer tags and wakes on writeback broadcasts. The block issues at most one ready row per cycle to its FU and frees the row when that FU writes back.

## Interface
Parameters
- NROWS, 3, number of scalar FUs; row index equals the `fu_scalar_t` encoding.
- TAG_W, FU_S_W (2), producer tag width; tag = FU index + 1, 0 = no dependency.

Ports
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- disp_valid  in  1  dispatch presents an instruction.
- disp_fu  in  2  target row (`fu_scalar_t`); value 3 is illegal.
- disp_row  in  $bits(fust_s_row_t)  row payload (rd, rs1, rs2, imm, t1, t2; busy ignored).
- disp_ready  out  1  dispatch accepted this cycle when disp_valid & disp_ready.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  completing FU tag; 0 ignored.
- flush  in  1  squash all non-executing rows.
- fu_ready  in  NROWS  per-FU accept.
- issue_valid  out  1  a row is issued this cycle.
- issue_fu  out  2  issued row index.
- issue_row  out  $bits(fust_s_row_t)  issued row contents, with t1 = t2 = 0.
- fust  out  $bits(fust_s_t)  live table snapshot; busy = state != EMPTY.
- row_state  out  3×`fust_state_e`  per-row state.

## Operation
- Per-row FSM (`fust_state_e`). Reset: all rows EMPTY, contents 0.
  - EMPTY -> WAIT on accept with either tag nonzero after wakeup.
  - EMPTY -> RDY on accept with both tags zero.
  - WAIT -> RDY at the edge where the last nonzero tag is cleared.
  - RDY -> EX on issue.
  - EX -> EMPTY on wb_valid & wb_tag == index+1.
- disp_ready = !flush & row_state[disp_fu] == EMPTY & disp_fu != 3, plus the wakeup restriction under Configuration.
- A row freed by writeback in cycle n is not reusable until cycle n+1; disp_ready reflects registered state only.
- Wakeup: on wb_valid with wb_tag != 0, every row with t1 == wb_tag clears t1, and likewise t2. This applies in WAIT, RDY or EX; EMPTY rows are untouched.
- Issue select is fixed priority BRANCH(2) > LD_ST(1) > ALU(0) among rows in RDY with fu_ready[i]=1. Outputs are combinational from registered state; at most one issue per cycle.
- Flush: WAIT/RDY rows -> EMPTY at the edge. EX rows are kept and still free on writeback. While flush=1: issue_valid=0, disp_ready=0.
- wb_tag matching a row not in EX: tags still clear, no state change.
- RST mid-operation: all rows EMPTY immediately (async); outputs go to reset values.

## Timing
- Reset values: disp_ready=1 (row EMPTY) unless flush or illegal fu; issue_valid=0, issue_fu=0, issue_row=0, fust=0, row_state=EMPTY.
- Dispatch with no dependencies accepted at edge n: RDY at n+1, issue_valid at n+1 if fu_ready.
- Writeback at cycle n clearing the last tag: row RDY after edge n, issue at n+1 (1-cycle wakeup-to-issue).
- Writeback from FU i at cycle n and issue of row i cannot coincide; row i is EX, not RDY.
- Simultaneous wakeup and flush: flush wins for WAIT/RDY rows.

## Configuration
- FUST_WB_BYPASS_EN defined: an accepted dispatch whose t1/t2 equals a same-cycle valid nonzero wb_tag captures that tag as 0. It enters RDY directly if both are resolved.
- Undefined: disp_ready is forced 0 when wb_valid & wb_tag != 0 & (disp_row.t1 == wb_tag | disp_row.t2 == wb_tag). Dispatch retries the next cycle with the corrected tag.

## Test plan
- Reset, then dispatch ALU row (rd=5, t1=t2=0) at cycle 1 with fu_ready=3'b111 -> issue_valid=1, issue_fu=0 at cycle 2; row_state[0]=EX at cycle 3.
- Dispatch LD_ST with t1=1 (waits on ALU); wb_valid, wb_tag=1 at cycle 4 -> row 1 RDY after edge 4, issue_fu=1 at cycle 5. The same wb frees row 0 (EMPTY) and disp_ready for ALU is 1 at cycle 5.
- Rows 0, 1 and 2 all RDY and all fu_ready=1 -> issue order 2, 1, 0 on three consecutive cycles. With fu_ready[2]=0, row 1 issues first.
- Dispatch t2=3 coincident with wb_tag=3: with FUST_WB_BYPASS_EN, row RDY next cycle; without it, disp_ready=0 that cycle and the retry is accepted next cycle.
- Row 0 EX, row 1 WAIT, row 2 RDY; assert flush -> rows 1 and 2 EMPTY, row 0 stays EX and clears on wb_tag=1. Assert RST mid-sequence -> all outputs at reset values within the same cycle.
